// File: rtl/life_engine.sv
// Game of Life engine for an 8x8 board: evaluates one cell per clock into a shadow
// board and commits it atomically, so the VGA renderer never sees a half-built generation.
module life_engine #(
  parameter int BIT_WIDTH      = 3,
  parameter int BIT_HEIGHT     = 3,
  parameter int FRAMES_PER_GEN = 60,
  parameter logic [(1 << (BIT_WIDTH + BIT_HEIGHT))-1:0] SEED = 64'h0000_0000_0000_1C00
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            run,
  input  logic                            load,
  input  logic                            vsync,
  input  logic [BIT_WIDTH+BIT_HEIGHT-1:0] rd_addr,
  output logic                            rd_cell,
  output logic                            busy,
  output logic [7:0]                      generation,
  output logic                            extinct
);

  localparam int AW   = BIT_WIDTH + BIT_HEIGHT;
  localparam int W    = 1 << BIT_WIDTH;
  localparam int H    = 1 << BIT_HEIGHT;
  localparam int SIZE = W * H;

  localparam logic [AW-1:0] LAST_IDX   = AW'(SIZE - 1);
  localparam logic [7:0]    LAST_FRAME = 8'(FRAMES_PER_GEN - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_COMMIT  = 2'd2;

  logic [SIZE-1:0] cur_q, cur_d;
  logic [SIZE-1:0] nxt_q, nxt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic [7:0]      gen_q, gen_d;
  logic [1:0]      state_q, state_d;
  logic            vsync_q;

  logic                  tick;
  logic                  start;
  logic [3:0]            nbr_cnt;
  logic                  new_cell;
  logic [BIT_HEIGHT-1:0] row;
  logic [BIT_WIDTH-1:0]  col;

  // Off-board coordinates read as dead, so row ends never wrap into the next row.
  function automatic logic cell_at(input logic [SIZE-1:0] b, input int r, input int c);
    logic [AW-1:0] k;
    if (r < 0 || r >= H || c < 0 || c >= W) return 1'b0;
    k = AW'(r * W + c);
    return b[k];
  endfunction

  assign row = idx_q[AW-1:BIT_WIDTH];
  assign col = idx_q[BIT_WIDTH-1:0];

  always_comb begin
    nbr_cnt = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (dr != 0 || dc != 0)
          nbr_cnt = nbr_cnt + 4'(cell_at(cur_q, int'(row) + dr, int'(col) + dc));
      end
    end
  end

  assign new_cell = cur_q[idx_q] ? (nbr_cnt == 4'd2 || nbr_cnt == 4'd3) : (nbr_cnt == 4'd3);
  assign tick     = vsync & ~vsync_q;

  always_comb begin
    // NOTE: every signal gets a default up front so no path through this block infers a latch.
    start       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    state_d     = state_q;
    idx_d       = idx_q;
    cur_d       = cur_q;
    nxt_d       = nxt_q;
    gen_d       = gen_q;

    if (tick && run) begin
      if (frame_cnt_q == LAST_FRAME) begin
        frame_cnt_d = '0;
        start       = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end

    // A start raised outside IDLE is simply lost.
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        nxt_d[idx_q] = new_cell;
        idx_d        = idx_q + AW'(1);
        if (idx_q == LAST_IDX) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        cur_d   = nxt_q;
        gen_d   = gen_q + 8'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reseed beats everything, aborting any computation without a commit.
    if (load) begin
      cur_d       = SEED;
      gen_d       = '0;
      frame_cnt_d = '0;
      idx_d       = '0;
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q       <= SEED;
      nxt_q       <= '0;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      gen_q       <= '0;
      vsync_q     <= 1'b0;
      state_q     <= S_IDLE;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      cur_q       <= cur_d;
      nxt_q       <= nxt_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      gen_q       <= gen_d;
      vsync_q     <= vsync;
      state_q     <= state_d;
    end
  end

  assign rd_cell    = cur_q[rd_addr];
  assign busy       = (state_q != S_IDLE);
  assign generation = gen_q;
  assign extinct    = ~|cur_q;

endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench for life_engine: four instances with different seeds share one
// stimulus stream and are compared every cycle against a board-level reference model.
`timescale 1ns/1ps
module tb_life_engine;

  localparam int NDUT = 4;
  localparam int FPG  = 4;
  localparam logic [63:0] SEED0 = 64'h0000_0000_0000_1C00;  // horizontal blinker
  localparam logic [63:0] SEED1 = 64'h0000_0000_0080_8080;  // column-7 line
  localparam logic [63:0] SEED2 = 64'h0000_0000_0000_0001;  // lone cell
  localparam logic [63:0] SEED3 = 64'h00E0_4A30_0C52_0700;  // irregular pattern

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            run = 1'b0;
  logic            load = 1'b0;
  logic            vsync = 1'b0;
  logic [5:0]      rd_addr = '0;
  logic [NDUT-1:0] rd_cell_w;
  logic [NDUT-1:0] busy_w;
  logic [NDUT-1:0] extinct_w;
  logic [7:0]      gen_w [NDUT];

  int n_checks = 0;
  int n_errors = 0;
  int busy_seen = 0;

  logic [63:0] m_board [NDUT];
  int          m_gen, m_fcnt, m_busy_left;
  logic        m_vs_prev;
  logic [63:0] snap [NDUT];

  always #5 clk = ~clk;

  life_engine #(.FRAMES_PER_GEN(FPG), .SEED(SEED0)) u_dut0 (
    .clk(clk), .reset(reset), .run(run), .load(load), .vsync(vsync), .rd_addr(rd_addr),
    .rd_cell(rd_cell_w[0]), .busy(busy_w[0]), .generation(gen_w[0]), .extinct(extinct_w[0]));
  life_engine #(.FRAMES_PER_GEN(FPG), .SEED(SEED1)) u_dut1 (
    .clk(clk), .reset(reset), .run(run), .load(load), .vsync(vsync), .rd_addr(rd_addr),
    .rd_cell(rd_cell_w[1]), .busy(busy_w[1]), .generation(gen_w[1]), .extinct(extinct_w[1]));
  life_engine #(.FRAMES_PER_GEN(FPG), .SEED(SEED2)) u_dut2 (
    .clk(clk), .reset(reset), .run(run), .load(load), .vsync(vsync), .rd_addr(rd_addr),
    .rd_cell(rd_cell_w[2]), .busy(busy_w[2]), .generation(gen_w[2]), .extinct(extinct_w[2]));
  life_engine #(.FRAMES_PER_GEN(FPG), .SEED(SEED3)) u_dut3 (
    .clk(clk), .reset(reset), .run(run), .load(load), .vsync(vsync), .rd_addr(rd_addr),
    .rd_cell(rd_cell_w[3]), .busy(busy_w[3]), .generation(gen_w[3]), .extinct(extinct_w[3]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] seed_of(input int k);
    case (k)
      0:       return SEED0;
      1:       return SEED1;
      2:       return SEED2;
      default: return SEED3;
    endcase
  endfunction

  // One Game of Life step on a bounded 8x8 grid, straight from the rules.
  function automatic logic [63:0] life_step(input logic [63:0] b);
    logic [63:0] n;
    logic [5:0]  a;
    int          cnt;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8) begin
              a = 6'((r + dr) * 8 + c + dc);
              cnt += int'(b[a]);
            end
          end
        end
        a = 6'(r * 8 + c);
        n[a] = b[a] ? (cnt == 2 || cnt == 3) : (cnt == 3);
      end
    end
    return n;
  endfunction

  // Timing model: a start arms a 65-cycle busy window, whose last edge commits the new board.
  task automatic model_update();
    logic tk, st;
    if (reset) begin
      for (int k = 0; k < NDUT; k++) m_board[k] = seed_of(k);
      m_gen = 0; m_fcnt = 0; m_busy_left = 0; m_vs_prev = 1'b0;
    end else begin
      tk = vsync && !m_vs_prev;
      m_vs_prev = vsync;
      if (load) begin
        for (int k = 0; k < NDUT; k++) m_board[k] = seed_of(k);
        m_gen = 0; m_fcnt = 0; m_busy_left = 0;
      end else begin
        st = 1'b0;
        if (tk && run) begin
          if (m_fcnt == FPG - 1) begin m_fcnt = 0; st = 1'b1; end
          else m_fcnt++;
        end
        if (m_busy_left > 0) begin
          m_busy_left--;
          if (m_busy_left == 0) begin
            for (int k = 0; k < NDUT; k++) m_board[k] = life_step(m_board[k]);
            m_gen = (m_gen + 1) % 256;
          end
        end else if (st) begin
          m_busy_left = 65;
        end
      end
    end
  endtask

  always @(posedge clk or posedge reset) model_update();

  // Continuous comparison of every instance against the model, mid-cycle.
  always @(negedge clk) begin
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("busy%0d", k), 64'(busy_w[k]), 64'(m_busy_left > 0));
      check($sformatf("gen%0d", k), 64'(gen_w[k]), 64'(m_gen));
      check($sformatf("extinct%0d", k), 64'(extinct_w[k]), 64'(m_board[k] == 64'd0));
      check($sformatf("rd_cell%0d", k), 64'(rd_cell_w[k]), 64'(m_board[k][rd_addr]));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #2;
    if (busy_w[0]) busy_seen++;
  endtask

  task automatic pulse();
    vsync = 1'b1; cyc(); cyc();
    vsync = 1'b0; cyc(); cyc(); cyc();
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_w[0] && n < 200) begin cyc(); n++; end
    check("idle_timeout", 64'(n < 200), 64'd1);
  endtask

  task automatic read_board();
    logic [5:0] a;
    for (int i = 0; i < 64; i++) begin
      a = 6'(i);
      rd_addr = a;
      cyc();
      for (int k = 0; k < NDUT; k++) snap[k][a] = rd_cell_w[k];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();

    check("reset_busy", 64'(busy_w[0]), 64'd0);
    check("reset_gen", 64'(gen_w[0]), 64'd0);
    check("reset_extinct", 64'(extinct_w[0]), 64'd0);
    read_board();
    check("reset_board0", snap[0], 64'h0000_0000_0000_1C00);
    check("reset_board3", snap[3], SEED3);

    // First generation: blinker flips, edge line stays on board, lone cell dies.
    run = 1'b1;
    busy_seen = 0;
    pulses(4);
    wait_idle();
    check("busy_len", 64'(busy_seen), 64'd65);
    read_board();
    check("blinker_g1", snap[0], 64'h0000_0000_0008_0808);
    check("gen_g1", 64'(gen_w[0]), 64'd1);
    check("edge_g1", snap[1], 64'h0000_0000_0000_C000);
    check("edge_cell16", 64'(snap[1][16]), 64'd0);
    check("single_g1", snap[2], 64'd0);
    check("single_extinct", 64'(extinct_w[2]), 64'd1);

    pulses(4);
    wait_idle();
    read_board();
    check("blinker_g2", snap[0], 64'h0000_0000_0000_1C00);
    check("gen_g2", 64'(gen_w[0]), 64'd2);

    // Frozen counting while run is low.
    run = 1'b0;
    pulses(10);
    check("frozen_gen", 64'(gen_w[0]), 64'd2);
    check("frozen_busy", 64'(busy_w[0]), 64'd0);
    run = 1'b1;
    pulses(3);
    check("resume_3ticks", 64'(busy_w[0]), 64'd0);
    pulse();
    check("resume_4ticks", 64'(busy_w[0]), 64'd1);
    wait_idle();
    check("gen_g3", 64'(gen_w[0]), 64'd3);

    // Reseed in the middle of COMPUTE, at cell 30.
    pulses(3);
    vsync = 1'b1;
    cyc();
    vsync = 1'b0;
    repeat (30) cyc();
    load = 1'b1;
    cyc();
    load = 1'b0;
    check("load_busy", 64'(busy_w[0]), 64'd0);
    check("load_gen", 64'(gen_w[0]), 64'd0);
    read_board();
    check("load_board", snap[0], SEED0);
    pulses(3);
    check("load_3ticks", 64'(busy_w[0]), 64'd0);
    pulse();
    check("load_4ticks", 64'(busy_w[0]), 64'd1);
    wait_idle();
    check("load_gen1", 64'(gen_w[0]), 64'd1);

    // Asynchronous reset in the middle of COMPUTE.
    pulses(4);
    repeat (10) cyc();
    #1 reset = 1'b1;
    #1;
    check("areset_busy", 64'(busy_w[0]), 64'd0);
    check("areset_gen", 64'(gen_w[0]), 64'd0);
    cyc();
    reset = 1'b0;
    read_board();
    check("areset_board0", snap[0], SEED0);
    check("areset_board2", snap[2], SEED2);

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 900; i++) begin
      vsync   = ($urandom_range(0, 3) == 0);
      run     = ($urandom_range(0, 15) != 0);
      load    = ($urandom_range(0, 249) == 0);
      rd_addr = 6'($urandom);
      cyc();
    end
    load = 1'b0;
    vsync = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/life_engine.md
Name: life_engine

Overview:
- Sequential Game of Life generation engine; holds the committed 8x8 board and feeds it to the VGA pixel renderer through a combinational read port.
- Counts VGA frames and computes one new generation every FRAMES_PER_GEN frames while run is high.
- Evaluates one cell per clock into a shadow board, then commits the whole board in a single cycle, so the renderer never sees a partial generation.

Parameters:
- BIT_WIDTH, 3, log2 of board width (columns).
- BIT_HEIGHT, 3, log2 of board height (rows).
- FRAMES_PER_GEN, 60, number of vsync rising edges per generation (legal range 1..255).
- SEED, 64'h0000_0000_0000_1C00, initial board; bit i is cell i, where i = row*8 + col.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = frame counting and evolution enabled.
- load  in  1  synchronous reseed strobe.
- vsync  in  1  VGA vsync from the sync generator; rising edge = frame tick.
- rd_addr  in  6  cell index requested by the renderer.
- rd_cell  out  1  committed state of cell rd_addr; combinational.
- busy  out  1  high while a generation is being computed or committed.
- generation  out  8  count of committed generations; wraps 255->0.
- extinct  out  1  high when every committed cell is 0.

Behaviour:
- Reset (async): cur <= SEED, nxt <= 0, idx <= 0, frame_cnt <= 0, generation <= 0, vsync_q <= 0, state <= IDLE. Outputs after reset: busy=0, generation=0, rd_cell=SEED[rd_addr], extinct=(SEED==0).
- Frame tick: tick = vsync & ~vsync_q, with vsync_q registered every clk.
- Frame counter, on a cycle with tick=1 and run=1:
  - frame_cnt == FRAMES_PER_GEN-1: frame_cnt <= 0 and a start request is raised.
  - otherwise: frame_cnt <= frame_cnt+1.
- run=0 freezes frame_cnt; ticks are ignored.
- A start request is accepted only in IDLE; a request arriving in any other state is dropped.
- FSM:
  - IDLE: on start, idx <= 0 and go to COMPUTE.
  - COMPUTE: nxt[idx] <= rule(cur, idx); idx increments each cycle; at idx == SIZE-1, go to COMMIT.
  - COMMIT: cur <= nxt; generation <= generation+1; go to IDLE.
- busy = (state != IDLE). busy is high for exactly SIZE+1 = 65 cycles, starting the cycle after the tick that raised start.
- Neighbour count, 0..8, 4-bit:
  - Sum of the 8 surrounding cells, using row/column coordinates, not linear index arithmetic.
  - Board is non-toroidal: coordinates outside 0..7 count as dead. Column 7 and column 0 of the next row are not adjacent.
- Rule:
  - Live cell: survives iff count is 2 or 3.
  - Dead cell: born iff count == 3.
- rd_cell and extinct always reflect cur only, never nxt.
- load=1 (highest synchronous priority):
  - cur <= SEED, generation <= 0, frame_cnt <= 0, idx <= 0, state <= IDLE.
  - Any in-progress computation is aborted with no commit.
  - A tick in the same cycle is discarded.
- Async reset mid-COMPUTE: same result as the reset values above; no partial commit.
- Simultaneous run deassert during COMPUTE: the current generation completes and commits; only counting stops.

Test Plan:
- Reset with default SEED -> cells 10,11,12 = 1, all others 0; generation=0; busy=0; extinct=0.
- Blinker, FRAMES_PER_GEN=4, run=1, 4 vsync pulses -> busy high for exactly 65 cycles; then only cells 3,11,19 set; generation=1. After 4 more pulses -> cells 10,11,12 again; generation=2.
- Edge, no wrap: SEED bits 7,15,23 set, one generation -> only cells 14,15 set; cell 16 must stay 0.
- run=0 with 10 vsync pulses -> board, generation and frame_cnt unchanged. Setting run=1 afterwards needs a full 4 further pulses to start.
- load asserted at COMPUTE idx=30 -> next cycle busy=0, board=SEED, generation=0. The next start needs 4 fresh ticks.
- Single-cell SEED (bit 0), one generation -> extinct=1, generation=1. Async reset asserted mid-COMPUTE -> immediate return to SEED, busy=0.
